// File: rtl/arb_pkg.sv
// Shared types and helpers for the burst-locking round-robin arbiter.
// Default sizing matches an 8-way arbiter with 4-beat bursts.
package arb_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StBusy
    } arb_state_e;

    localparam int unsigned DefN        = 8;
    localparam int unsigned DefMaxBurst = 4;
    localparam int unsigned DefIdw      = $clog2(DefN);
    localparam int unsigned DefBcw      = $clog2(DefMaxBurst + 1);

    // OR-reduction encoder; only valid for zero or one-hot inputs.
    function automatic logic [4:0] onehot_to_idx(input logic [31:0] oh);
        logic [4:0] idx;
        idx = '0;
        for (int i = 0; i < 32; i++) begin
            if (oh[i]) begin
                idx = idx | 5'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: high-priority requesters mask the rest,
// then the first set bit scanning upward from start (wrapping) wins.
module rr_pick
    import arb_pkg::*;
#(
    parameter int unsigned N   = 8,
    parameter int unsigned IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   prio,
    input  logic [IDW-1:0] start,
    output logic           valid,
    output logic [N-1:0]   win,
    output logic [IDW-1:0] win_idx
);

    logic [N-1:0] cand;
    int           idx;

    always_comb begin
        cand  = (|(req & prio)) ? (req & prio) : req;
        valid = 1'b0;
        win   = '0;
        idx   = 0;
        for (int i = 0; i < int'(N); i++) begin
            idx = (int'(start) + i) % int'(N);
            if (!valid && cand[idx]) begin
                valid    = 1'b1;
                win[idx] = 1'b1;
            end
        end
        win_idx = IDW'(onehot_to_idx(32'(win)));
    end

endmodule

// File: rtl/arb_rr_burst.sv
// N-way round-robin arbiter with registered grant, priority override and
// burst locking: a winner keeps the target for up to MAX_BURST acked beats.
module arb_rr_burst
    import arb_pkg::*;
#(
    parameter int unsigned N         = 8,
    parameter int unsigned MAX_BURST = 4,
    parameter int unsigned IDW       = $clog2(N),
    parameter int unsigned BCW       = $clog2(MAX_BURST + 1)
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic [N-1:0]   req_i,
    input  logic [N-1:0]   prio,
    output logic [N-1:0]   ack_i,
    output logic           req_o,
    input  logic           ack_o,
    output logic [N-1:0]   gnt_o,
    output logic [IDW-1:0] gnt_id_o,
    output logic [BCW-1:0] beat_cnt_o
);

    arb_state_e     state_q, state_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic [IDW-1:0] gnt_id_q, gnt_id_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [BCW-1:0] beat_cnt_q, beat_cnt_d;
    logic           req_q, req_d;

    logic [IDW-1:0] sel, start;
    logic           pick_valid, release_g;
    logic [N-1:0]   pick_win;
    logic [IDW-1:0] pick_idx;

    // While busy the pick only matters on release, where it starts after g.
    assign sel   = (state_q == StBusy) ? gnt_id_q : ptr_q;
    assign start = (sel == IDW'(N - 1)) ? '0 : sel + IDW'(1);

    rr_pick #(
        .N   (N),
        .IDW (IDW)
    ) u_pick (
        .req     (req_i),
        .prio    (prio),
        .start   (start),
        .valid   (pick_valid),
        .win     (pick_win),
        .win_idx (pick_idx)
    );

    assign release_g = (ack_o && (beat_cnt_q == BCW'(MAX_BURST - 1))) || !req_i[gnt_id_q];

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        gnt_id_d   = gnt_id_q;
        ptr_d      = ptr_q;
        beat_cnt_d = beat_cnt_q;
        req_d      = req_q;
        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    state_d    = StBusy;
                    gnt_d      = pick_win;
                    gnt_id_d   = pick_idx;
                    beat_cnt_d = '0;
                    req_d      = 1'b1;
                end
            end
            StBusy: begin
                if (ack_o) begin
                    beat_cnt_d = beat_cnt_q + BCW'(1);
                end
                if (release_g) begin
                    ptr_d      = gnt_id_q;
                    beat_cnt_d = '0;
                    if (pick_valid) begin
                        gnt_d    = pick_win;
                        gnt_id_d = pick_idx;
                    end else begin
                        state_d  = StIdle;
                        gnt_d    = '0;
                        gnt_id_d = '0;
                        req_d    = 1'b0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= StIdle;
            gnt_q      <= '0;
            gnt_id_q   <= '0;
            ptr_q      <= IDW'(N - 1);
            beat_cnt_q <= '0;
            req_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            gnt_id_q   <= gnt_id_d;
            ptr_q      <= ptr_d;
            beat_cnt_q <= beat_cnt_d;
            req_q      <= req_d;
        end
    end

    assign ack_i      = gnt_q & {N{ack_o}};
    assign req_o      = req_q;
    assign gnt_o      = gnt_q;
    assign gnt_id_o   = gnt_id_q;
    assign beat_cnt_o = beat_cnt_q;

endmodule

// File: tb/tb_arb_rr_burst.sv
// Scoreboard bench for arb_rr_burst (N=8, MAX_BURST=4): each stimulus cycle
// queues the expected outputs; a monitor pops and compares on the falling edge.
module tb_arb_rr_burst;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [7:0] req_i = '0;
    logic [7:0] prio = '0;
    logic       ack_o = 1'b0;
    logic [7:0] ack_i;
    logic       req_o;
    logic [7:0] gnt_o;
    logic [2:0] gnt_id_o;
    logic [2:0] beat_cnt_o;

    typedef struct packed {
        logic [7:0] gnt;
        logic [2:0] id;
        logic [2:0] cnt;
        logic       req;
        logic [7:0] ack;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always #5 clk = ~clk;

    arb_rr_burst #(
        .N         (8),
        .MAX_BURST (4)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .req_i      (req_i),
        .prio       (prio),
        .ack_i      (ack_i),
        .req_o      (req_o),
        .ack_o      (ack_o),
        .gnt_o      (gnt_o),
        .gnt_id_o   (gnt_id_o),
        .beat_cnt_o (beat_cnt_o)
    );

    function automatic logic [2:0] idx_of(input logic [7:0] oh);
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) return 3'(i);
        end
        return 3'd0;
    endfunction

    // Drive one cycle of inputs; eg/ec are the grant and beat count expected
    // to be visible during this cycle (the result of earlier edges).
    task automatic step(input logic rst, input logic [7:0] r, input logic [7:0] p,
                        input logic a, input logic [7:0] eg, input int ec);
        exp_t e;
        @(posedge clk);
        #1;
        rstn  = rst;
        req_i = r;
        prio  = p;
        ack_o = a;
        e.gnt = eg;
        e.id  = idx_of(eg);
        e.cnt = 3'(ec);
        e.req = |eg;
        e.ack = eg & {8{a}};
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (gnt_o !== e.gnt || gnt_id_o !== e.id || beat_cnt_o !== e.cnt ||
                    req_o !== e.req || ack_i !== e.ack) begin
                    errors++;
                    $display("FAIL outputs cyc %0d: got gnt=%h id=%0d cnt=%0d req_o=%b ack_i=%h, expected gnt=%h id=%0d cnt=%0d req_o=%b ack_i=%h",
                             cyc, gnt_o, gnt_id_o, beat_cnt_o, req_o, ack_i,
                             e.gnt, e.id, e.cnt, e.req, e.ack);
                end
            end
        end
    end

    initial begin : stim
        // Reset
        step(0, 8'h00, 8'h00, 0, 8'h00, 0);
        step(1, 8'h00, 8'h00, 0, 8'h00, 0);

        // Single requester: 4-beat burst, burst-limit release, re-grant, drop
        step(1, 8'h01, 8'h00, 0, 8'h00, 0);
        step(1, 8'h01, 8'h00, 1, 8'h01, 0);
        step(1, 8'h01, 8'h00, 1, 8'h01, 1);
        step(1, 8'h01, 8'h00, 1, 8'h01, 2);
        step(1, 8'h01, 8'h00, 1, 8'h01, 3);
        step(1, 8'h01, 8'h00, 0, 8'h01, 0);
        step(1, 8'h00, 8'h00, 0, 8'h01, 0);
        step(1, 8'h00, 8'h00, 0, 8'h00, 0);

        // All request, ack always: ack ignored in idle, then 1..7,0,1 each 4 beats
        step(1, 8'hFF, 8'h00, 1, 8'h00, 0);
        for (int g = 1; g <= 9; g++) begin
            for (int k = 0; k < 4; k++) begin
                step(1, 8'hFF, 8'h00, 1, 8'(32'd1 << (g % 8)), k);
            end
        end
        step(1, 8'h00, 8'h00, 0, 8'h04, 0);
        step(1, 8'h00, 8'h00, 0, 8'h00, 0);

        // Priority: 7 flagged mid-burst cannot pre-empt 2, then wins after it
        step(1, 8'h04, 8'h00, 0, 8'h00, 0);
        step(1, 8'h84, 8'h80, 1, 8'h04, 0);
        step(1, 8'h84, 8'h80, 1, 8'h04, 1);
        step(1, 8'h84, 8'h00, 0, 8'h04, 2);
        step(1, 8'h84, 8'h80, 1, 8'h04, 2);
        step(1, 8'h84, 8'h80, 1, 8'h04, 3);
        // Wrap: ptr=7, 0 wins next; then 7 alone is re-granted after a burst
        step(1, 8'h81, 8'h00, 1, 8'h80, 0);
        step(1, 8'h01, 8'h00, 0, 8'h80, 1);
        step(1, 8'h00, 8'h00, 0, 8'h01, 0);
        step(1, 8'h80, 8'h00, 0, 8'h00, 0);
        step(1, 8'h80, 8'h00, 1, 8'h80, 0);
        step(1, 8'h80, 8'h00, 1, 8'h80, 1);
        step(1, 8'h80, 8'h00, 1, 8'h80, 2);
        step(1, 8'h80, 8'h00, 1, 8'h80, 3);
        step(1, 8'h80, 8'h00, 0, 8'h80, 0);
        step(1, 8'h00, 8'h00, 0, 8'h80, 0);

        // Drop without ack moves grant 5 -> 6; drop with ack counts the beat
        step(1, 8'h20, 8'h00, 0, 8'h00, 0);
        step(1, 8'h60, 8'h00, 1, 8'h20, 0);
        step(1, 8'h40, 8'h00, 0, 8'h20, 1);
        step(1, 8'h40, 8'h00, 1, 8'h40, 0);
        step(1, 8'h00, 8'h00, 1, 8'h40, 1);
        step(1, 8'h00, 8'h00, 1, 8'h00, 0);

        // Async reset mid-burst, then requester 0 has first priority
        step(1, 8'h08, 8'h00, 0, 8'h00, 0);
        step(1, 8'h08, 8'h00, 1, 8'h08, 0);
        step(1, 8'h08, 8'h00, 1, 8'h08, 1);
        step(0, 8'h08, 8'h00, 1, 8'h00, 0);
        step(1, 8'hFF, 8'h00, 0, 8'h00, 0);
        step(1, 8'hFF, 8'h00, 0, 8'h01, 0);
        step(1, 8'h00, 8'h00, 0, 8'h01, 0);
        step(1, 8'h00, 8'h00, 0, 8'h00, 0);

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) begin
            @(negedge clk);
        end
        #1;
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
